// File: rtl/accel_rs_queue.sv
// In-order reservation queue feeding the memory-to-memory accelerator.
// Captures dispatched ops, snoops the CDBs for operands, issues the oldest ready entry, reports completion.
module accel_rs_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_CDB = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [OP_W-1:0]             alloc_op,
    input  logic [TAG_W-1:0]            alloc_dest,
    input  logic [TAG_W-1:0]            alloc_r1,
    input  logic [TAG_W-1:0]            alloc_r2,
    input  logic [DATA_W-1:0]           alloc_src1,
    input  logic [DATA_W-1:0]           alloc_src2,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic                        flush,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [OP_W-1:0]             issue_op,
    output logic [DATA_W-1:0]           issue_src1,
    output logic [DATA_W-1:0]           issue_src2,
    input  logic                        accel_done,
    output logic                        done_valid,
    output logic [TAG_W-1:0]            done_tag,
    output logic [DATA_W-1:0]           done_data,
    output logic [$clog2(DEPTH+1)-1:0]  free_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  r1;
        logic [TAG_W-1:0]  r2;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   free_q, free_d;
    logic               inflight_q, inflight_d;
    logic               killed_q, killed_d;
    logic [TAG_W-1:0]   itag_q, itag_d;
    logic               done_valid_q, done_valid_d;
    logic [TAG_W-1:0]   done_tag_q, done_tag_d;
    logic               alloc_fire, issue_fire;

    // Returns {hit, data}; tag 0 never matches and the lowest bus index wins.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        if (tag != '0) begin
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (vld[i] && (tags[i*TAG_W +: TAG_W] == tag)) begin
                    res = {1'b1, data[i*DATA_W +: DATA_W]};
                end
            end
        end
        return res;
    endfunction

    assign alloc_ready = (count_q != CNT_W'(DEPTH));
    assign issue_valid = ent_q[head_q].valid && (ent_q[head_q].r1 == '0) &&
                         (ent_q[head_q].r2 == '0) && !inflight_q && !flush;
    assign issue_op    = ent_q[head_q].op;
    assign issue_src1  = ent_q[head_q].src1;
    assign issue_src2  = ent_q[head_q].src2;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign issue_fire  = issue_valid && issue_ready;
    assign done_valid  = done_valid_q;
    assign done_tag    = done_tag_q;
    assign done_data   = '0;
    assign free_count  = free_q;

    // Next-state: storage, pointers, snoop, and accelerator tracking.
    always_comb begin
        logic [DATA_W:0] hit;
        hit          = '0;
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        killed_d     = killed_q;
        itag_d       = itag_q;
        done_valid_d = 1'b0;
        done_tag_d   = '0;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d  = tail_q;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    hit = cdb_match(ent_q[i].r1, cdb_valid, cdb_tag, cdb_data);
                    if (hit[DATA_W]) begin
                        ent_d[i].r1   = '0;
                        ent_d[i].src1 = hit[DATA_W-1:0];
                    end
                    hit = cdb_match(ent_q[i].r2, cdb_valid, cdb_tag, cdb_data);
                    if (hit[DATA_W]) begin
                        ent_d[i].r2   = '0;
                        ent_d[i].src2 = hit[DATA_W-1:0];
                    end
                end
            end
            if (issue_fire) begin
                ent_d[head_q].valid = 1'b0;
                head_d              = head_q + PTR_W'(1);
            end
            if (alloc_fire) begin
                ent_d[tail_q].valid = 1'b1;
                ent_d[tail_q].op    = alloc_op;
                ent_d[tail_q].dest  = alloc_dest;
                ent_d[tail_q].r1    = alloc_r1;
                ent_d[tail_q].r2    = alloc_r2;
                ent_d[tail_q].src1  = alloc_src1;
                ent_d[tail_q].src2  = alloc_src2;
                hit = cdb_match(alloc_r1, cdb_valid, cdb_tag, cdb_data);
                if (hit[DATA_W]) begin
                    ent_d[tail_q].r1   = '0;
                    ent_d[tail_q].src1 = hit[DATA_W-1:0];
                end
                hit = cdb_match(alloc_r2, cdb_valid, cdb_tag, cdb_data);
                if (hit[DATA_W]) begin
                    ent_d[tail_q].r2   = '0;
                    ent_d[tail_q].src2 = hit[DATA_W-1:0];
                end
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
        end

        // A killed op still has to drain through its accel_done, silently.
        if (accel_done && inflight_q) begin
            inflight_d = 1'b0;
            killed_d   = 1'b0;
            if (!killed_q) begin
                done_valid_d = 1'b1;
                done_tag_d   = itag_q;
            end
        end else if (issue_fire) begin
            inflight_d = 1'b1;
            itag_d     = ent_q[head_q].dest;
        end else if (flush && inflight_q) begin
            killed_d = 1'b1;
        end
    end

    assign free_d = CNT_W'(DEPTH) - count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            free_q       <= CNT_W'(DEPTH);
            inflight_q   <= 1'b0;
            killed_q     <= 1'b0;
            itag_q       <= '0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            free_q       <= free_d;
            inflight_q   <= inflight_d;
            killed_q     <= killed_d;
            itag_q       <= itag_d;
            done_valid_q <= done_valid_d;
            done_tag_q   <= done_tag_d;
        end
    end

endmodule

// File: tb/tb_accel_rs_queue.sv
// Scoreboard bench for accel_rs_queue: expected issues/completions queued at allocate, checked at DUT output.
module tb_accel_rs_queue;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [2:0]   alloc_op;
    logic [4:0]   alloc_dest, alloc_r1, alloc_r2;
    logic [31:0]  alloc_src1, alloc_src2;
    logic [3:0]   cdb_valid;
    logic [19:0]  cdb_tag;
    logic [127:0] cdb_data;
    logic         flush;
    logic         issue_valid, issue_ready;
    logic [2:0]   issue_op;
    logic [31:0]  issue_src1, issue_src2;
    logic         accel_done;
    logic         done_valid;
    logic [4:0]   done_tag;
    logic [31:0]  done_data;
    logic [2:0]   free_count;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
    } iss_t;

    iss_t       iq[$];
    logic [4:0] dq[$];
    int         n_pass  = 0;
    int         n_total = 0;

    accel_rs_queue dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_dest(alloc_dest), .alloc_r1(alloc_r1), .alloc_r2(alloc_r2),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .accel_done(accel_done),
        .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare every issue handshake and completion pulse against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (issue_valid && issue_ready) begin
                iss_t e;
                n_total++;
                if (iq.size() == 0) begin
                    $display("FAIL issue_unexpected: got op=%0d src1=%h src2=%h, expected none", issue_op, issue_src1, issue_src2);
                end else begin
                    e = iq.pop_front();
                    if ({issue_op, issue_src1, issue_src2} !== e) begin
                        $display("FAIL issue_payload: got op=%0d src1=%h src2=%h, expected op=%0d src1=%h src2=%h",
                                 issue_op, issue_src1, issue_src2, e.op, e.s1, e.s2);
                    end else begin
                        n_pass++;
                    end
                end
            end
            if (done_valid) begin
                logic [4:0] t;
                n_total++;
                if (dq.size() == 0) begin
                    $display("FAIL done_unexpected: got done_tag=%0d, expected no completion", done_tag);
                end else begin
                    t = dq.pop_front();
                    if (done_tag !== t || done_data !== 32'd0) begin
                        $display("FAIL done_payload: got tag=%0d data=%h, expected tag=%0d data=0", done_tag, done_data, t);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input int b, input logic [4:0] t, input logic [31:0] d);
        cdb_valid[b]        = 1'b1;
        cdb_tag[b*5 +: 5]   = t;
        cdb_data[b*32 +: 32] = d;
    endtask

    task automatic clr_cdb();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
    endtask

    task automatic do_alloc(input logic [2:0] op, input logic [4:0] dest, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] e1, input logic [31:0] e2);
        alloc_valid = 1'b1;
        alloc_op    = op;
        alloc_dest  = dest;
        alloc_r1    = r1;
        alloc_r2    = r2;
        alloc_src1  = s1;
        alloc_src2  = s2;
        iq.push_back('{op: op, s1: e1, s2: e2});
        dq.push_back(dest);
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic issue_one();
        for (int k = 0; k < 50 && !issue_valid; k++) step();
        if (!issue_valid) begin
            n_total++;
            $display("FAIL issue_timeout: got issue_valid=0 after 50 cycles, expected 1");
        end else begin
            issue_ready = 1'b1;
            step();
            issue_ready = 1'b0;
        end
    endtask

    task automatic complete_one(input int dly);
        repeat (dly) step();
        accel_done = 1'b1;
        step();
        accel_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        alloc_valid = 0; alloc_op = 0; alloc_dest = 0; alloc_r1 = 0; alloc_r2 = 0;
        alloc_src1 = 0; alloc_src2 = 0; flush = 0; issue_ready = 0; accel_done = 0;
        clr_cdb();
        repeat (3) step();
        n_total += 5;
        if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready: got %b, expected 1", alloc_ready); else n_pass++;
        if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %b, expected 0", issue_valid); else n_pass++;
        if (done_valid !== 1'b0) $display("FAIL rst_done_valid: got %b, expected 0", done_valid); else n_pass++;
        if (done_tag !== 5'd0) $display("FAIL rst_done_tag: got %0d, expected 0", done_tag); else n_pass++;
        if (free_count !== 3'd4) $display("FAIL rst_free_count: got %0d, expected 4", free_count); else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_alloc(3'd3, 5'd7, 5'd0, 5'd0, 32'h1000, 32'h2000, 32'h1000, 32'h2000);
        n_total += 3;
        if (issue_valid !== 1'b1) $display("FAIL basic_issue_valid: got %b, expected 1", issue_valid); else n_pass++;
        if (issue_src1 !== 32'h1000) $display("FAIL basic_src1: got %h, expected 1000", issue_src1); else n_pass++;
        if (free_count !== 3'd3) $display("FAIL basic_free_count: got %0d, expected 3", free_count); else n_pass++;
        issue_one();
        n_total++;
        if (issue_valid !== 1'b0) $display("FAIL basic_inflight_block: got %b, expected 0", issue_valid); else n_pass++;
        complete_one(10);
        n_total += 2;
        if (done_valid !== 1'b1) $display("FAIL basic_done_valid: got %b, expected 1", done_valid); else n_pass++;
        if (done_tag !== 5'd7) $display("FAIL basic_done_tag: got %0d, expected 7", done_tag); else n_pass++;
        step();
        n_total += 2;
        if (done_valid !== 1'b0) $display("FAIL basic_done_pulse: got %b, expected 0", done_valid); else n_pass++;
        if (done_tag !== 5'd0) $display("FAIL basic_done_tag_idle: got %0d, expected 0", done_tag); else n_pass++;
    endtask

    task automatic test_bypass();
        set_cdb(2, 5'd5, 32'hABCD);
        do_alloc(3'd1, 5'd10, 5'd5, 5'd0, 32'hDEAD, 32'h55, 32'hABCD, 32'h55);
        clr_cdb();
        n_total += 2;
        if (issue_valid !== 1'b1) $display("FAIL bypass_ready: got %b, expected 1", issue_valid); else n_pass++;
        if (issue_src1 !== 32'hABCD) $display("FAIL bypass_src1: got %h, expected abcd", issue_src1); else n_pass++;
        issue_one();
        complete_one(2);
        do_alloc(3'd2, 5'd11, 5'd0, 5'd9, 32'h77, 32'hBAD, 32'h77, 32'h900);
        step();
        n_total++;
        if (issue_valid !== 1'b0) $display("FAIL pending_r2: got issue_valid=%b, expected 0", issue_valid); else n_pass++;
        set_cdb(0, 5'd9, 32'h900);
        set_cdb(3, 5'd9, 32'h933);
        step();
        clr_cdb();
        n_total++;
        if (issue_src2 !== 32'h900) $display("FAIL multi_cdb_priority: got %h, expected 900", issue_src2); else n_pass++;
        issue_one();
        complete_one(1);
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 4; i++) begin
            do_alloc(3'(i), 5'(12 + i), 5'd4, 5'd0, 32'hBEEF, 32'(i), 32'h4000, 32'(i));
        end
        n_total += 3;
        if (alloc_ready !== 1'b0) $display("FAIL full_alloc_ready: got %b, expected 0", alloc_ready); else n_pass++;
        if (free_count !== 3'd0) $display("FAIL full_free_count: got %0d, expected 0", free_count); else n_pass++;
        if (issue_valid !== 1'b0) $display("FAIL full_pending: got issue_valid=%b, expected 0", issue_valid); else n_pass++;
        set_cdb(1, 5'd4, 32'h4000);
        step();
        clr_cdb();
        issue_ready = 1'b1;
        n_total += 2;
        if (issue_valid !== 1'b1) $display("FAIL full_head_ready: got %b, expected 1", issue_valid); else n_pass++;
        if (alloc_ready !== 1'b0) $display("FAIL full_issue_alloc_ready: got %b, expected 0", alloc_ready); else n_pass++;
        step();
        issue_ready = 1'b0;
        n_total += 2;
        if (alloc_ready !== 1'b1) $display("FAIL after_issue_alloc_ready: got %b, expected 1", alloc_ready); else n_pass++;
        if (free_count !== 3'd1) $display("FAIL after_issue_free_count: got %0d, expected 1", free_count); else n_pass++;
        do_alloc(3'd5, 5'd16, 5'd0, 5'd0, 32'h5, 32'h50, 32'h5, 32'h50);
        complete_one(1);
        issue_one();
        do_alloc(3'd6, 5'd17, 5'd0, 5'd0, 32'h6, 32'h60, 32'h6, 32'h60);
        repeat (4) begin
            complete_one(1);
            issue_one();
        end
        complete_one(1);
        step();
        n_total++;
        if (free_count !== 3'd4) $display("FAIL wrap_drained: got free_count=%0d, expected 4", free_count); else n_pass++;
    endtask

    task automatic test_in_order();
        do_alloc(3'd4, 5'd20, 5'd0, 5'd6, 32'hA1, 32'h0, 32'hA1, 32'h666);
        do_alloc(3'd5, 5'd21, 5'd0, 5'd0, 32'hB1, 32'hB2, 32'hB1, 32'hB2);
        step();
        n_total++;
        if (issue_valid !== 1'b0) $display("FAIL in_order_hold: got issue_valid=%b, expected 0", issue_valid); else n_pass++;
        set_cdb(1, 5'd6, 32'h666);
        step();
        clr_cdb();
        n_total++;
        if (issue_valid !== 1'b1 || issue_op !== 3'd4) $display("FAIL in_order_head: got valid=%b op=%0d, expected 1/4", issue_valid, issue_op); else n_pass++;
        issue_one();
        step();
        n_total++;
        if (issue_valid !== 1'b0) $display("FAIL single_outstanding: got issue_valid=%b, expected 0", issue_valid); else n_pass++;
        complete_one(3);
        n_total++;
        if (issue_valid !== 1'b1 || issue_op !== 3'd5) $display("FAIL second_issue: got valid=%b op=%0d, expected 1/5", issue_valid, issue_op); else n_pass++;
        issue_one();
        complete_one(1);
    endtask

    task automatic test_flush();
        do_alloc(3'd1, 5'd22, 5'd0, 5'd0, 32'h22, 32'h22, 32'h22, 32'h22);
        issue_one();
        for (int i = 0; i < 3; i++) begin
            do_alloc(3'd2, 5'(23 + i), 5'd0, 5'd0, 32'(i), 32'(i), 32'(i), 32'(i));
        end
        n_total++;
        if (free_count !== 3'd1) $display("FAIL pre_flush_free: got %0d, expected 1", free_count); else n_pass++;
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_op = 3'd7; alloc_dest = 5'd30; alloc_r1 = 0; alloc_r2 = 0;
        step();
        flush = 1'b0;
        alloc_valid = 1'b0;
        iq.delete();
        dq.delete();
        n_total += 2;
        if (free_count !== 3'd4) $display("FAIL flush_free_count: got %0d, expected 4", free_count); else n_pass++;
        if (issue_valid !== 1'b0) $display("FAIL flush_empty: got issue_valid=%b, expected 0", issue_valid); else n_pass++;
        complete_one(2);
        n_total++;
        if (done_valid !== 1'b0) $display("FAIL killed_done: got done_valid=%b, expected 0", done_valid); else n_pass++;
        do_alloc(3'd6, 5'd26, 5'd0, 5'd0, 32'h26, 32'h62, 32'h26, 32'h62);
        issue_one();
        complete_one(2);
        step();
    endtask

    task automatic test_async_reset();
        do_alloc(3'd7, 5'd27, 5'd0, 5'd0, 32'h27, 32'h72, 32'h27, 32'h72);
        issue_one();
        do_alloc(3'd7, 5'd28, 5'd0, 5'd0, 32'h28, 32'h82, 32'h28, 32'h82);
        #3;
        reset_n = 1'b0;
        #1;
        iq.delete();
        dq.delete();
        n_total += 3;
        if (issue_valid !== 1'b0) $display("FAIL async_issue_valid: got %b, expected 0", issue_valid); else n_pass++;
        if (free_count !== 3'd4) $display("FAIL async_free_count: got %0d, expected 4", free_count); else n_pass++;
        if (alloc_ready !== 1'b1) $display("FAIL async_alloc_ready: got %b, expected 1", alloc_ready); else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        complete_one(1);
        n_total++;
        if (done_valid !== 1'b0) $display("FAIL stray_done: got done_valid=%b, expected 0", done_valid); else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_fill_wrap();
        test_in_order();
        test_flush();
        test_async_reset();
        repeat (2) step();
        n_total++;
        if (iq.size() != 0 || dq.size() != 0)
            $display("FAIL scoreboard_drain: got %0d issues and %0d completions outstanding, expected 0", iq.size(), dq.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
